// File: rtl/rv_regfile_2r1w.sv
// RISC-V integer register file: x0..x31, one write port, two combinational read ports.
// x0 is hardwired to zero and has no storage; x1..x31 are enable-gated registers
// selected by a one-hot write-address decoder.
// Optional build macro: RV_REGFILE_BYPASS_EN -- forwards the write port's data to a
// read port in the same cycle when both target the same non-zero register.
module rv_regfile_2r1w #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_ena,
   input  logic [4:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [4:0]       rd_addr0,
   output logic [WIDTH-1:0] rd_data0,
   input  logic [4:0]       rd_addr1,
   output logic [WIDTH-1:0] rd_data1
);

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;

   // Bit 0 of the decoder is dropped: x0 has no storage to enable.
   logic [NUM_REGS-1:1] wr_sel;
   logic [WIDTH-1:0]    regs [1:NUM_REGS-1];

   // One-hot write-address decoder, fully gated by wr_ena.
   always_comb begin
      wr_sel = '0;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         if (wr_ena && (wr_addr == ADDR_W'(k))) begin
            wr_sel[k] = 1'b1;
         end
      end
   end

   // Storage for x1..x31; synchronous reset takes priority over writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 1; k < NUM_REGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         for (int unsigned k = 1; k < NUM_REGS; k++) begin
            if (wr_sel[k]) begin
               regs[k] <= wr_data;
            end
         end
      end
   end

`ifdef RV_REGFILE_BYPASS_EN
   logic fwd_ok;
   assign fwd_ok = wr_ena && !rst && (wr_addr != '0);
`endif

   // Read port 0: stored contents, x0 reads zero, optional same-cycle forwarding.
   always_comb begin
      rd_data0 = '0;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         if (rd_addr0 == ADDR_W'(k)) begin
            rd_data0 = regs[k];
         end
      end
`ifdef RV_REGFILE_BYPASS_EN
      if (fwd_ok && (rd_addr0 == wr_addr)) begin
         rd_data0 = wr_data;
      end
`endif
   end

   // Read port 1: identical to port 0, independent address.
   always_comb begin
      rd_data1 = '0;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         if (rd_addr1 == ADDR_W'(k)) begin
            rd_data1 = regs[k];
         end
      end
`ifdef RV_REGFILE_BYPASS_EN
      if (fwd_ok && (rd_addr1 == wr_addr)) begin
         rd_data1 = wr_data;
      end
`endif
   end

endmodule

// File: tb/tb_rv_regfile_2r1w.sv
// Self-checking bench for rv_regfile_2r1w: scoreboard of expected read data,
// reference register model, directed scenarios plus a random back-to-back run.
module tb_rv_regfile_2r1w;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_ena;
   logic [4:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic [4:0]   rd_addr0;
   logic [W-1:0] rd_data0;
   logic [4:0]   rd_addr1;
   logic [W-1:0] rd_data1;

   logic [W-1:0] model [32];
   logic [W-1:0] exp_q [$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rv_regfile_2r1w #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_ena   (wr_ena),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr0 (rd_addr0),
      .rd_data0 (rd_data0),
      .rd_addr1 (rd_addr1),
      .rd_data1 (rd_data1)
   );

   // Apply one rising edge, updating the reference model from the driven inputs.
   task automatic cycle();
      if (rst) begin
         for (int k = 0; k < 32; k++) model[k] = '0;
      end else if (wr_ena && wr_addr != 5'd0) begin
         model[wr_addr] = wr_data;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [W-1:0] d);
      wr_ena = 1'b1; wr_addr = a; wr_data = d;
      cycle();
      wr_ena = 1'b0;
   endtask

   // Drive read addresses and queue the model's expected data.
   task automatic drive_reads(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr0 = a0; rd_addr1 = a1;
      exp_q.push_back(model[a0]);
      exp_q.push_back(model[a1]);
   endtask

   task automatic test_reset();
      logic [W-1:0] e0, e1;
      rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      rd_addr0 = '0; rd_addr1 = '0;
      cycle();
      rst = 1'b0; wr_ena = 1'b0;
      for (int a = 0; a < 32; a++) begin
         rd_addr0 = 5'(a); rd_addr1 = 5'(31 - a);
         exp_q.push_back(32'h0); exp_q.push_back(32'h0);
         #1;
         e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
         total += 2;
         if (rd_data0 !== e0) begin
            bad++; $display("FAIL reset port0 addr=%0d got=%h exp=%h", a, rd_data0, e0);
         end
         if (rd_data1 !== e1) begin
            bad++; $display("FAIL reset port1 addr=%0d got=%h exp=%h", 31 - a, rd_data1, e1);
         end
      end
   endtask

   task automatic test_write_readback();
      logic [W-1:0] e0, e1;
      do_write(5'd1, 32'h00000001);
      do_write(5'd31, 32'hFFFFFFFF);
      rd_addr0 = 5'd1; rd_addr1 = 5'd31;
      exp_q.push_back(32'h00000001); exp_q.push_back(32'hFFFFFFFF);
      #1;
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      total += 2;
      if (rd_data0 !== e0) begin
         bad++; $display("FAIL readback x1 got=%h exp=%h", rd_data0, e0);
      end
      if (rd_data1 !== e1) begin
         bad++; $display("FAIL readback x31 got=%h exp=%h", rd_data1, e1);
      end
      for (int a = 2; a < 31; a++) begin
         rd_addr0 = 5'(a); rd_addr1 = 5'(a);
         exp_q.push_back(32'h0); exp_q.push_back(32'h0);
         #1;
         e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
         total += 2;
         if (rd_data0 !== e0 || rd_data1 !== e1) begin
            bad++; $display("FAIL untouched x%0d got=%h/%h exp=%h", a, rd_data0, rd_data1, e0);
         end
      end
   endtask

   task automatic test_x0();
      logic [W-1:0] e0, e1;
      do_write(5'd0, 32'h12345678);
      rd_addr0 = 5'd0; rd_addr1 = 5'd0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      total += 2;
      if (rd_data0 !== e0) begin
         bad++; $display("FAIL x0_port0 got=%h exp=%h", rd_data0, e0);
      end
      if (rd_data1 !== e1) begin
         bad++; $display("FAIL x0_port1 got=%h exp=%h", rd_data1, e1);
      end
   endtask

   task automatic test_enable_gating();
      logic [W-1:0] e0, e1;
      wr_ena = 1'b0; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
      rd_addr0 = 5'd7; rd_addr1 = 5'd7;
      for (int i = 0; i < 4; i++) cycle();
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      total += 2;
      if (rd_data0 !== e0 || rd_data1 !== e1) begin
         bad++; $display("FAIL enable_gating x7 got=%h/%h exp=%h", rd_data0, rd_data1, e0);
      end
   endtask

   task automatic test_same_addr();
      logic [W-1:0] e0, e1, pre;
      do_write(5'd3, 32'h11111111);
`ifdef RV_REGFILE_BYPASS_EN
      pre = 32'h22222222;
`else
      pre = 32'h11111111;
`endif
      wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h22222222;
      rd_addr0 = 5'd3; rd_addr1 = 5'd3;
      exp_q.push_back(pre); exp_q.push_back(pre);
      #1;
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      total += 2;
      if (rd_data0 !== e0) begin
         bad++; $display("FAIL rdw_before port0 got=%h exp=%h", rd_data0, e0);
      end
      if (rd_data1 !== e1) begin
         bad++; $display("FAIL rdw_before port1 got=%h exp=%h", rd_data1, e1);
      end
      cycle();
      wr_ena = 1'b0;
      exp_q.push_back(32'h22222222); exp_q.push_back(32'h22222222);
      #1;
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      total += 2;
      if (rd_data0 !== e0) begin
         bad++; $display("FAIL rdw_after port0 got=%h exp=%h", rd_data0, e0);
      end
      if (rd_data1 !== e1) begin
         bad++; $display("FAIL rdw_after port1 got=%h exp=%h", rd_data1, e1);
      end
   endtask

   task automatic test_sweep();
      logic [W-1:0] e0, e1;
      for (int k = 1; k < 32; k++) do_write(5'(k), W'(k) * 32'h01010101);
      for (int k = 0; k < 32; k++) begin
         rd_addr0 = 5'(k); rd_addr1 = 5'(31 - k);
         exp_q.push_back(W'(k) * 32'h01010101);
         exp_q.push_back(W'(31 - k) * 32'h01010101);
         #1;
         e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
         total += 2;
         if (rd_data0 !== e0) begin
            bad++; $display("FAIL sweep port0 x%0d got=%h exp=%h", k, rd_data0, e0);
         end
         if (rd_data1 !== e1) begin
            bad++; $display("FAIL sweep port1 x%0d got=%h exp=%h", 31 - k, rd_data1, e1);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] e0, e1;
      for (int i = 0; i < 300; i++) begin
         wr_ena  = ($urandom_range(0, 3) != 0);
         wr_addr = 5'($urandom_range(0, 31));
         wr_data = $urandom;
         rd_addr0 = 5'($urandom_range(0, 31));
         rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         e0 = model[rd_addr0];
         e1 = model[rd_addr1];
`ifdef RV_REGFILE_BYPASS_EN
         if (wr_ena && wr_addr != 5'd0 && rd_addr0 == wr_addr) e0 = wr_data;
         if (wr_ena && wr_addr != 5'd0 && rd_addr1 == wr_addr) e1 = wr_data;
`endif
         exp_q.push_back(e0); exp_q.push_back(e1);
         #1;
         e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
         total += 2;
         if (rd_data0 !== e0) begin
            bad++; $display("FAIL b2b port0 i=%0d addr=%0d got=%h exp=%h", i, rd_addr0, rd_data0, e0);
         end
         if (rd_data1 !== e1) begin
            bad++; $display("FAIL b2b port1 i=%0d addr=%0d got=%h exp=%h", i, rd_addr1, rd_data1, e1);
         end
         cycle();
      end
      wr_ena = 1'b0;
      for (int k = 0; k < 32; k += 2) begin
         drive_reads(5'(k), 5'(k + 1));
         #1;
         e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
         total += 2;
         if (rd_data0 !== e0 || rd_data1 !== e1) begin
            bad++; $display("FAIL b2b_final x%0d/x%0d got=%h/%h exp=%h/%h", k, k + 1, rd_data0, rd_data1, e0, e1);
         end
      end
   endtask

   // Debug dump: all 32 registers with ABI names, in hex and decimal, via read port 0.
   task automatic dump_regs();
      string abi [32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                          "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                          "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                          "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
      for (int k = 0; k < 32; k++) begin
         rd_addr0 = 5'(k);
         #1;
         $display("x%0d (%s) = 0x%h (%0d)", k, abi[k], rd_data0, rd_data0);
      end
   endtask

   initial begin
      rst = 1'b0; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr0 = '0; rd_addr1 = '0;
      for (int k = 0; k < 32; k++) model[k] = '0;
      @(negedge clk);
      test_reset();
      test_write_readback();
      test_x0();
      test_enable_gating();
      test_same_addr();
      test_sweep();
      test_back_to_back();
      dump_regs();
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so a stalled run still terminates.
   initial begin
      #200000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/rv_regfile_2r1w.md
Name: rv_regfile_2r1w

Overview:
- RISC-V integer register file: 32 architectural registers x0..x31, one write port, two independent combinational read ports.
- Built from a 5-to-32 one-hot write-address decoder and 31 enable-gated width-parameterised registers; x0 is a hardwired constant zero.
- Sits in the CPU datapath between instruction decode (rs1/rs2/rd) and the ALU/writeback stage.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_ena  input  1  write enable for the write port.
- wr_addr  input  5  destination register index.
- wr_data  input  WIDTH  data to write.
- rd_addr0  input  5  read port 0 register index.
- rd_data0  output  WIDTH  read port 0 data, combinational.
- rd_addr1  input  5  read port 1 register index.
- rd_data1  output  WIDTH  read port 1 data, combinational.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset: on a rising edge with rst=1, x1..x31 all become 0. Reset has priority over wr_ena in the same cycle. After reset, both read ports return 0 for every address.
- Write decoder: 5-to-32 one-hot decoder. Output bit k is 1 when wr_addr==k and wr_ena=1; otherwise all bits are 0. wr_ena gates the decoder enable; a write never occurs while wr_ena=0.
- Write: on a rising edge with rst=0, wr_ena=1 and wr_addr=k (k in 1..31), xk takes wr_data. All other registers hold. Write latency is one cycle; the new value is visible on the read ports after that edge.
- x0: always reads 0. A write to address 0 is silently discarded, and no storage exists for x0.
- Read: rd_dataN = x[rd_addrN], purely combinational, with no clock latency.
- Both ports may read the same address simultaneously, and both return the same value.
- Read-during-write to the same address (feature disabled): the read returns the old register contents until the clock edge.
- Register data is treated as raw bits; the block performs no sign interpretation or extension.
- No X propagation after reset. Before the first reset, register contents are undefined except x0.
- Debug: a non-synthesisable task prints all 32 registers with their ABI names (zero, ra, sp, gp, tp, t0-t6, s0-s11, a0-a7) in hex and decimal.

Optional Feature:
- Macro: RV_REGFILE_BYPASS_EN.
- When defined: write-to-read forwarding. If wr_ena=1, rst=0, wr_addr!=0 and rd_addrN==wr_addr, then rd_dataN = wr_data combinationally in the same cycle.
  - Applies independently to each read port.
  - Address 0 is never bypassed and always reads 0.
- When undefined: no forwarding; reads always return stored contents as described in Behaviour.

Test Plan:
- Reset then read: assert rst for one edge with wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF -> all reads of x0..x31 return 0x00000000, including x5 (reset beats write).
- Write/readback: write x1=0x00000001 and x31=0xFFFFFFFF on successive edges; read rd_addr0=1, rd_addr1=31 -> 0x00000001 and 0xFFFFFFFF. All other registers remain 0.
- x0 immutability: wr_ena=1, wr_addr=0, wr_data=0x12345678 -> rd_data0 for address 0 reads 0x00000000 after the edge.
- Enable gating: wr_ena=0, wr_addr=7, wr_data=0xA5A5A5A5 for several edges -> x7 keeps its prior value (0 after reset).
- Same-address read/write: x3=0x11111111 stored; drive wr_ena=1, wr_addr=3, wr_data=0x22222222 with rd_addr0=rd_addr1=3.
  - Before the edge: both ports read 0x11111111 without RV_REGFILE_BYPASS_EN, 0x22222222 with it.
  - After the edge: both ports read 0x22222222.
- Sweep: write xk = k*0x01010101 for k=1..31, then read all pairs (k, 31-k) -> exact values, with x0 = 0.
